oldland_decode: RTL and testbench

//  Decode stage: sits directly downstream of fetch. Consumes the fetched instr and pc_plus_4.

---
 rtl/oldland_decode.sv | 165 ++++++++++++++++
 tb/tb_oldland_decode.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/oldland_decode.sv
// oldland_decode: decode stage with 8x32 register file and a registered
// control/operand bundle for execute. One-cycle latency, never stalls.
// Optional build macro OLDLAND_DECODE_BYPASS_EN: write-through from the
// writeback port into the operand read path in the same cycle.
module oldland_decode #(
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus_4,
  input  logic        branch_taken,
  input  logic        wb_en,
  input  logic [2:0]  wb_sel,
  input  logic [31:0] wb_val,
  output logic [31:0] ra_val,
  output logic [31:0] rb_val,
  output logic [31:0] imm32,
  output logic        use_imm,
  output logic [3:0]  alu_opc,
  output logic [2:0]  rd_sel,
  output logic        rd_wr_en,
  output logic        is_branch,
  output logic [2:0]  branch_cond,
  output logic        mem_load,
  output logic        mem_store,
  output logic [1:0]  mem_width,
  output logic        illegal_instr,
  output logic [31:0] pc_plus_4_out
);

  typedef struct packed {
    logic [31:0] ra_val;
    logic [31:0] rb_val;
    logic [31:0] imm32;
    logic        use_imm;
    logic [3:0]  alu_opc;
    logic [2:0]  rd_sel;
    logic        rd_wr_en;
    logic        is_branch;
    logic [2:0]  branch_cond;
    logic        mem_load;
    logic        mem_store;
    logic [1:0]  mem_width;
    logic        illegal_instr;
  } bundle_t;

  logic [31:0] regs_q [NUM_REGS];
  bundle_t     bundle_d, bundle_q;
  logic [31:0] pc_q;
  logic [31:0] ra_rd, rb_rd;

  logic [1:0]  cls;
  logic [3:0]  opc;
  logic [2:0]  ra, rb, rd;
  logic [31:0] sext;

  assign cls  = instr[31:30];
  assign opc  = instr[29:26];
  assign rb   = instr[8:6];
  assign ra   = instr[5:3];
  assign rd   = instr[2:0];
  assign sext = {{16{instr[25]}}, instr[25:10]};

  // Register file read port; bypass build forwards a same-cycle write
`ifdef OLDLAND_DECODE_BYPASS_EN
  assign ra_rd = (wb_en && wb_sel == ra) ? wb_val : regs_q[ra];
  assign rb_rd = (wb_en && wb_sel == rb) ? wb_val : regs_q[rb];
`else
  assign ra_rd = regs_q[ra];
  assign rb_rd = regs_q[rb];
`endif

  // Register file write port; async reset clears every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[wb_sel] <= wb_val;
    end
  end

  // Instruction decode into the next bundle; NOP, illegal and flush all
  // collapse to an all-zero bundle (illegal keeps only its flag)
  always_comb begin
    logic illegal;
    bundle_d = '0;
    illegal  = 1'b0;
    unique case (cls)
      2'b00: begin
        bundle_d.ra_val   = ra_rd;
        bundle_d.rb_val   = rb_rd;
        bundle_d.alu_opc  = opc;
        bundle_d.rd_sel   = rd;
        bundle_d.rd_wr_en = 1'b1;
        bundle_d.use_imm  = instr[9];
        bundle_d.imm32    = sext;
      end
      2'b01: begin
        // use_imm marks a pc-relative target; clear means target is ra_val
        bundle_d.ra_val      = ra_rd;
        bundle_d.rb_val      = rb_rd;
        bundle_d.is_branch   = 1'b1;
        bundle_d.branch_cond = opc[2:0];
        bundle_d.imm32       = {sext[29:0], 2'b00};
        bundle_d.use_imm     = ~instr[9];
        if (opc[3]) begin
          bundle_d.rd_sel   = rd;
          bundle_d.rd_wr_en = 1'b1;
        end
      end
      2'b10: begin
        if (opc[1:0] == 2'b11) begin
          illegal = 1'b1;
        end else begin
          bundle_d.ra_val    = ra_rd;
          bundle_d.rb_val    = rb_rd;
          bundle_d.imm32     = sext;
          bundle_d.use_imm   = 1'b1;
          bundle_d.mem_width = opc[1:0];
          if (opc[3]) begin
            bundle_d.mem_store = 1'b1;
          end else begin
            bundle_d.mem_load = 1'b1;
            bundle_d.rd_sel   = rd;
            bundle_d.rd_wr_en = 1'b1;
          end
        end
      end
      default: illegal = (opc != 4'd0);
    endcase
    if (illegal || branch_taken) begin
      bundle_d               = '0;
      bundle_d.illegal_instr = illegal & ~branch_taken;
    end
  end

  // Bundle and forwarded pc register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bundle_q <= '0;
      pc_q     <= RESET_PC;
    end else begin
      bundle_q <= bundle_d;
      pc_q     <= pc_plus_4;
    end
  end

  assign ra_val        = bundle_q.ra_val;
  assign rb_val        = bundle_q.rb_val;
  assign imm32         = bundle_q.imm32;
  assign use_imm       = bundle_q.use_imm;
  assign alu_opc       = bundle_q.alu_opc;
  assign rd_sel        = bundle_q.rd_sel;
  assign rd_wr_en      = bundle_q.rd_wr_en;
  assign is_branch     = bundle_q.is_branch;
  assign branch_cond   = bundle_q.branch_cond;
  assign mem_load      = bundle_q.mem_load;
  assign mem_store     = bundle_q.mem_store;
  assign mem_width     = bundle_q.mem_width;
  assign illegal_instr = bundle_q.illegal_instr;
  assign pc_plus_4_out = pc_q;

endmodule

// File: tb/tb_oldland_decode.sv
// tb_oldland_decode: directed and random stimulus against a behavioural
// decode/register-file model.
module tb_oldland_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pc_plus_4, wb_val;
  logic        branch_taken, wb_en;
  logic [2:0]  wb_sel;
  logic [31:0] ra_val, rb_val, imm32, pc_plus_4_out;
  logic        use_imm, rd_wr_en, is_branch, mem_load, mem_store, illegal_instr;
  logic [3:0]  alu_opc;
  logic [2:0]  rd_sel, branch_cond;
  logic [1:0]  mem_width;

  int total = 0;
  int bad   = 0;
  logic [31:0] mregs [8];

  always #5 clk = ~clk;

  oldland_decode dut (
    .clk(clk), .rst(rst), .instr(instr), .pc_plus_4(pc_plus_4),
    .branch_taken(branch_taken), .wb_en(wb_en), .wb_sel(wb_sel), .wb_val(wb_val),
    .ra_val(ra_val), .rb_val(rb_val), .imm32(imm32), .use_imm(use_imm),
    .alu_opc(alu_opc), .rd_sel(rd_sel), .rd_wr_en(rd_wr_en), .is_branch(is_branch),
    .branch_cond(branch_cond), .mem_load(mem_load), .mem_store(mem_store),
    .mem_width(mem_width), .illegal_instr(illegal_instr), .pc_plus_4_out(pc_plus_4_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int cls, input int opc, input int imm16,
                                     input int b9, input int rb, input int ra, input int rd);
    return (cls << 30) | (opc << 26) | ((imm16 & 32'hFFFF) << 10) | (b9 << 9)
           | (rb << 6) | (ra << 3) | rd;
  endfunction

  // One clock: drive at negedge, predict from the model, compare after posedge
  task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                      input logic bt, input logic we, input logic [2:0] ws,
                      input logic [31:0] wv);
    int cls, opc, ra, rb, rd, simm;
    bit nop, ill, bypass;
    logic [31:0] e_ra, e_rb, e_imm, e_pc;
    int e_ui, e_alu, e_rd, e_wr, e_br, e_cond, e_ld, e_st, e_w, e_ill;
    logic [17:0] e_ctl, g_ctl;
    @(negedge clk);
    rst = r; instr = ins; pc_plus_4 = pc; branch_taken = bt;
    wb_en = we; wb_sel = ws; wb_val = wv;
    @(posedge clk);
    cls = int'(ins[31:30]); opc = int'(ins[29:26]);
    ra = int'(ins[5:3]); rb = int'(ins[8:6]); rd = int'(ins[2:0]);
    simm = int'($signed(ins[25:10]));
`ifdef OLDLAND_DECODE_BYPASS_EN
    bypass = 1;
`else
    bypass = 0;
`endif
    e_ra = (bypass && we && ws == 3'(ra)) ? wv : mregs[ra];
    e_rb = (bypass && we && ws == 3'(rb)) ? wv : mregs[rb];
    e_imm = 0; e_ui = 0; e_alu = 0; e_rd = 0; e_wr = 0; e_br = 0; e_cond = 0;
    e_ld = 0; e_st = 0; e_w = 0; e_ill = 0; nop = 0; ill = 0;
    e_pc = pc;
    if (cls == 0) begin
      e_alu = opc; e_wr = 1; e_rd = rd; e_ui = ins[9]; e_imm = simm;
    end else if (cls == 1) begin
      e_br = 1; e_cond = opc % 8; e_imm = simm * 4; e_ui = !ins[9];
      if (opc >= 8) begin e_wr = 1; e_rd = rd; end
    end else if (cls == 2) begin
      if (opc % 4 == 3) ill = 1;
      else begin
        e_imm = simm; e_ui = 1; e_w = opc % 4;
        if (opc < 8) begin e_ld = 1; e_wr = 1; e_rd = rd; end
        else e_st = 1;
      end
    end else begin
      if (opc == 0) nop = 1; else ill = 1;
    end
    if (r || nop || ill || bt) begin
      e_ra = 0; e_rb = 0; e_imm = 0; e_ui = 0; e_alu = 0; e_rd = 0; e_wr = 0;
      e_br = 0; e_cond = 0; e_ld = 0; e_st = 0; e_w = 0;
      e_ill = (ill && !bt && !r) ? 1 : 0;
    end
    if (r) begin
      e_pc = 0;
      for (int i = 0; i < 8; i++) mregs[i] = 0;
    end else if (we) begin
      mregs[ws] = wv;
    end
    e_ctl = {1'(e_ui), 4'(e_alu), 3'(e_rd), 1'(e_wr), 1'(e_br), 3'(e_cond),
             1'(e_ld), 1'(e_st), 2'(e_w), 1'(e_ill)};
    #1;
    g_ctl = {use_imm, alu_opc, rd_sel, rd_wr_en, is_branch, branch_cond,
             mem_load, mem_store, mem_width, illegal_instr};
    chk("ra_val", ra_val, e_ra);
    chk("rb_val", rb_val, e_rb);
    chk("imm32", imm32, e_imm);
    chk("ctl", 32'(g_ctl), 32'(e_ctl));
    chk("pc_out", pc_plus_4_out, e_pc);
  endtask

  localparam logic [31:0] NOP = 32'hC000_0000;

  initial begin
    for (int i = 0; i < 8; i++) mregs[i] = 0;
    rst = 1; instr = NOP; pc_plus_4 = 0; branch_taken = 0;
    wb_en = 0; wb_sel = 0; wb_val = 0;
    // reset state
    step(1, NOP, 32'h40, 0, 0, 0, 0);
    chk("rst_pc", pc_plus_4_out, 32'h0);
    step(0, NOP, 32'h4, 0, 0, 0, 0);

    // arith immediate after writing r2=5
    step(0, NOP, 32'h8, 0, 1, 3'd2, 32'd5);
    step(0, mk(0, 1, 16'hFFFE, 1, 0, 2, 1), 32'hC, 0, 0, 0, 0);
    chk("ar_ra", ra_val, 32'd5);
    chk("ar_imm", imm32, 32'hFFFF_FFFE);
    chk("ar_flags", {use_imm, rd_wr_en, rd_sel}, 5'b11001);

    // relative branch
    step(0, mk(1, 0, 16'h0004, 0, 0, 0, 0), 32'h100, 0, 0, 0, 0);
    chk("br_imm", imm32, 32'h10);
    chk("br_pc", pc_plus_4_out, 32'h100);
    chk("br_is", is_branch, 1'b1);

    // flushed store
    step(0, mk(2, 8 + 2, 16'h0010, 1, 1, 2, 3), 32'h104, 1, 0, 0, 0);
    chk("fl_st", {mem_store, rd_wr_en, illegal_instr}, 3'b000);

    // write-through vs registered read
    step(0, NOP, 32'h108, 0, 1, 3'd3, 32'h1234);
    step(0, mk(0, 2, 0, 0, 0, 3, 4), 32'h10C, 0, 1, 3'd3, 32'hDEAD);
`ifdef OLDLAND_DECODE_BYPASS_EN
    chk("byp_ra", ra_val, 32'hDEAD);
`else
    chk("byp_ra", ra_val, 32'h1234);
`endif

    // illegal encodings, one bundle each, then clean
    step(0, mk(3, 5, 0, 0, 0, 0, 0), 32'h110, 0, 0, 0, 0);
    chk("ill_c3", illegal_instr, 1'b1);
    step(0, mk(2, 3, 16'h0001, 1, 1, 1, 1), 32'h114, 0, 0, 0, 0);
    chk("ill_w3", {illegal_instr, mem_load, rd_wr_en}, 3'b100);
    step(0, NOP, 32'h118, 0, 0, 0, 0);
    chk("ill_clr", illegal_instr, 1'b0);

    // reset mid-stream with a coincident write
    step(0, NOP, 32'h11C, 0, 1, 3'd6, 32'hABCD);
    step(1, mk(0, 1, 0, 0, 0, 0, 0), 32'h120, 0, 1, 3'd6, 32'h5555);
    chk("rst_mid_pc", pc_plus_4_out, 32'h0);
    step(0, mk(0, 0, 0, 0, 0, 6, 0), 32'h4, 0, 0, 0, 0);
    chk("rst_rd", ra_val, 32'h0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 7) == 0) ins = NOP;
      step(($urandom_range(0, 63) == 0), ins, $urandom, ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
